// File: rtl/ad80305_rx_pkg.sv
// AD80305 RX FIFO shared definitions: state encoding and rate defaults,
// shared by the RX interface and the read-side FIFO controller.
package ad80305_rx_pkg;

  localparam logic [2:0] RX_ST_IDLE  = 3'd0;
  localparam logic [2:0] RX_ST_FLUSH = 3'd1;
  localparam logic [2:0] RX_ST_FILL  = 3'd2;
  localparam logic [2:0] RX_ST_RUN   = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = RX_ST_IDLE,
    ST_FLUSH = RX_ST_FLUSH,
    ST_FILL  = RX_ST_FILL,
    ST_RUN   = RX_ST_RUN
  } rx_st_e;

  localparam int RX_RD_DIV   = 4;
  localparam int RX_CLR_CYC  = 8;
  localparam int RX_FILL_LVL = 8;

endpackage

// File: rtl/ad80305_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Used for the FILL timeout timer and the optional error statistics.
module ad80305_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ad80305_rx_fifo_ctrl.sv
// AD80305 RX CDC FIFO read-side sequencer (flush, pre-fill, paced reads).
// Optional error statistics enabled by defining RX_FIFO_STATS_EN.
module ad80305_rx_fifo_ctrl
  import ad80305_rx_pkg::*;
#(
  parameter int RD_DIV    = RX_RD_DIV,
  parameter int CLR_CYC   = RX_CLR_CYC,
  parameter int FILL_LVL  = RX_FILL_LVL,
  parameter int OVF_LVL   = 14,
  parameter int FILL_TO   = 256,
  parameter int USEDW_W   = 4
`ifdef RX_FIFO_STATS_EN
  ,
  parameter int ERR_CNT_W = 16
`endif
) (
  input  logic               i_fpga_clk_125p,
  input  logic               i_fpga_rst_125p,
  input  logic               i_enable,
  input  logic               i_rdempty,
  input  logic [USEDW_W-1:0] i_rdusedw,
  output logic               o_fifo_aclr,
  output logic               o_rd_req,
  output logic               o_iq_valid,
  output logic               o_locked,
  output logic [2:0]         o_state,
  output logic               o_err_pulse
`ifdef RX_FIFO_STATS_EN
  ,
  input  logic               i_stats_clr,
  output logic [ERR_CNT_W-1:0] o_udf_cnt,
  output logic [ERR_CNT_W-1:0] o_ovf_cnt,
  output logic [ERR_CNT_W-1:0] o_noclk_cnt
`endif
);

  localparam int DIV_W = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
  localparam int TO_W  = $clog2(FILL_TO);

  rx_st_e            st, st_nxt;
  logic [DIV_W-1:0]  div;
  logic [TO_W-1:0]   tmr;
  logic              st_chg;
  logic              slot, fill_ok, udf, ovf, tmo, flush_done;

  assign st_chg     = (st_nxt != st);
  assign slot       = (st == ST_RUN) && (div == DIV_W'(RD_DIV - 1));
  assign fill_ok    = (i_rdusedw >= USEDW_W'(FILL_LVL));
  assign udf        = slot && i_rdempty;
  assign ovf        = (st == ST_RUN) && (i_rdusedw >= USEDW_W'(OVF_LVL));
  assign tmo        = (st == ST_FILL) && !fill_ok &&
                      (tmr == TO_W'(FILL_TO - 1));
  assign flush_done = (st == ST_FLUSH) && (tmr == TO_W'(CLR_CYC - 1));

  // Shared timer: FLUSH length and FILL timeout, restarted on state entry
  ad80305_sat_cnt #(.W(TO_W)) u_tmr (
    .clk   (i_fpga_clk_125p),
    .rst_n (i_fpga_rst_125p),
    .clr   (st_chg),
    .inc   (1'b1),
    .cnt   (tmr)
  );

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      st         <= ST_IDLE;
      div        <= '0;
      o_iq_valid <= 1'b0;
    end else begin
      st         <= st_nxt;
      o_iq_valid <= o_rd_req;
      if (st_chg) begin
        div <= '0;
      end else if (st == ST_RUN) begin
        div <= (div == DIV_W'(RD_DIV - 1)) ? '0 : div + 1'b1;
      end
    end
  end

  always_comb begin
    st_nxt      = st;
    o_fifo_aclr = 1'b0;
    o_rd_req    = 1'b0;
    o_locked    = 1'b0;
    o_state     = st;
    o_err_pulse = udf || ovf || tmo;
    unique case (st)
      ST_IDLE: begin
        o_fifo_aclr = 1'b1;
        st_nxt      = ST_FLUSH;
      end
      ST_FLUSH: begin
        o_fifo_aclr = 1'b1;
        if (flush_done) st_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (fill_ok)  st_nxt = ST_RUN;
        else if (tmo) st_nxt = ST_FLUSH;
      end
      ST_RUN: begin
        o_locked = 1'b1;
        o_rd_req = slot && !i_rdempty && !ovf;
        if (udf || ovf) st_nxt = ST_FLUSH;
      end
      default: st_nxt = ST_IDLE;
    endcase
    // Disable overrides every transition and suppresses the read
    if (!i_enable) begin
      st_nxt   = ST_IDLE;
      o_rd_req = 1'b0;
    end
  end

`ifdef RX_FIFO_STATS_EN
  ad80305_sat_cnt #(.W(ERR_CNT_W)) u_udf_cnt (
    .clk   (i_fpga_clk_125p),
    .rst_n (i_fpga_rst_125p),
    .clr   (i_stats_clr),
    .inc   (udf),
    .cnt   (o_udf_cnt)
  );

  // A same-clock underflow takes the blame over an overflow
  ad80305_sat_cnt #(.W(ERR_CNT_W)) u_ovf_cnt (
    .clk   (i_fpga_clk_125p),
    .rst_n (i_fpga_rst_125p),
    .clr   (i_stats_clr),
    .inc   (ovf && !udf),
    .cnt   (o_ovf_cnt)
  );

  ad80305_sat_cnt #(.W(ERR_CNT_W)) u_noclk_cnt (
    .clk   (i_fpga_clk_125p),
    .rst_n (i_fpga_rst_125p),
    .clr   (i_stats_clr),
    .inc   (tmo),
    .cnt   (o_noclk_cnt)
  );
`endif

endmodule

// File: tb/tb_ad80305_rx_fifo_ctrl.sv
// Self-checking bench for ad80305_rx_fifo_ctrl: cycle-age reference
// model plus directed scenarios and randomized traffic.
module tb_ad80305_rx_fifo_ctrl;

  localparam int RD_DIV   = 4;
  localparam int CLR_CYC  = 8;
  localparam int FILL_LVL = 8;
  localparam int OVF_LVL  = 14;
  localparam int FILL_TO  = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rdempty = 1'b1;
  logic [3:0] rdusedw = '0;
  logic       fifo_aclr, rd_req, iq_valid, locked, err_pulse;
  logic [2:0] state;
  logic       stats_clr = 1'b0;
`ifdef RX_FIFO_STATS_EN
  logic [15:0] udf_cnt, ovf_cnt, noclk_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: state plus cycles spent in it
  int m_st = 0;
  int m_age = 0;
  bit m_prev_rd = 0;
  int m_udf = 0, m_ovf = 0, m_noclk = 0;

  bit last_aclr, last_rd, last_valid, last_locked, last_err;
  int last_state;

  always #4 clk = ~clk;

  ad80305_rx_fifo_ctrl dut (
    .i_fpga_clk_125p (clk),
    .i_fpga_rst_125p (rst_n),
    .i_enable        (enable),
    .i_rdempty       (rdempty),
    .i_rdusedw       (rdusedw),
    .o_fifo_aclr     (fifo_aclr),
    .o_rd_req        (rd_req),
    .o_iq_valid      (iq_valid),
    .o_locked        (locked),
    .o_state         (state),
    .o_err_pulse     (err_pulse)
`ifdef RX_FIFO_STATS_EN
    ,
    .i_stats_clr     (stats_clr),
    .o_udf_cnt       (udf_cnt),
    .o_ovf_cnt       (ovf_cnt),
    .o_noclk_cnt     (noclk_cnt)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_age = 0;
    m_prev_rd = 0;
    m_udf = 0;
    m_ovf = 0;
    m_noclk = 0;
  endtask

  // Called at posedge+1: drive inputs, check at negedge, advance model
  task automatic step(input bit en, input bit emp, input int uw);
    bit slot, udf, ovf, tmo, e_rd;
    int nst;
    enable  = en;
    rdempty = emp;
    rdusedw = 4'(uw);
    #3;
    slot = (m_st == 3) && ((m_age % RD_DIV) == RD_DIV - 1);
    udf  = slot && emp;
    ovf  = (m_st == 3) && (uw >= OVF_LVL);
    tmo  = (m_st == 2) && (uw < FILL_LVL) && (m_age == FILL_TO - 1);
    e_rd = slot && !emp && !ovf && en;
    chk("aclr", fifo_aclr, int'(m_st <= 1));
    chk("rd_req", rd_req, int'(e_rd));
    chk("iq_valid", iq_valid, int'(m_prev_rd));
    chk("locked", locked, int'(m_st == 3));
    chk("state", state, m_st);
    chk("err_pulse", err_pulse, int'(udf || ovf || tmo));
`ifdef RX_FIFO_STATS_EN
    chk("udf_cnt", udf_cnt, m_udf);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("noclk_cnt", noclk_cnt, m_noclk);
`endif
    last_aclr = fifo_aclr;
    last_rd = rd_req;
    last_valid = iq_valid;
    last_locked = locked;
    last_err = err_pulse;
    last_state = int'(state);
    nst = m_st;
    if (!en) nst = 0;
    else case (m_st)
      0: nst = 1;
      1: if (m_age == CLR_CYC - 1) nst = 2;
      2: if (uw >= FILL_LVL) nst = 3;
         else if (tmo) nst = 1;
      default: if (udf || ovf) nst = 1;
    endcase
    @(posedge clk);
    m_age = (nst != m_st) ? 0 : m_age + 1;
    m_st = nst;
    m_prev_rd = e_rd;
    if (stats_clr) begin
      m_udf = 0;
      m_ovf = 0;
      m_noclk = 0;
    end else begin
      if (udf && m_udf < 65535) m_udf++;
      if (ovf && !udf && m_ovf < 65535) m_ovf++;
      if (tmo && m_noclk < 65535) m_noclk++;
    end
    #1;
  endtask

  task automatic goto_fill();
    stats_clr = 1'b1;
    step(0, 0, 0);
    stats_clr = 1'b0;
    for (int i = 0; i < 40 && m_st != 2; i++) step(1, 0, 0);
    chk("reach_fill", state, 2);
  endtask

  task automatic goto_run();
    goto_fill();
    step(1, 0, FILL_LVL);
    chk("reach_run", state, 3);
  endtask

  task automatic goto_slot();
    for (int i = 0; i < 8; i++) begin
      if (m_st == 3 && (m_age % RD_DIV) == RD_DIV - 1) break;
      step(1, 0, FILL_LVL);
    end
    chk("reach_slot", int'(m_st == 3 && (m_age % RD_DIV) == RD_DIV - 1), 1);
  endtask

  initial begin
    int n, pat, reads, errs, unlock, fcnt, wph;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_aclr", fifo_aclr, 1);
    chk("rst_state", state, 0);
    chk("rst_rd", rd_req, 0);
    chk("rst_valid", iq_valid, 0);
    chk("rst_locked", locked, 0);
    rst_n = 1'b1;
    model_reset();

    // Bring-up: 8 flush clocks, fill, then every 4th clock a read
    step(0, 0, 0);
    step(1, 0, 0);
    n = 0;
    for (int i = 0; i < CLR_CYC; i++) begin
      step(1, 0, 0);
      if (last_aclr && last_state == 1) n++;
    end
    chk("flush_len", n, 8);
    step(1, 0, 0);
    chk("fill_aclr", last_aclr, 0);
    chk("fill_state", last_state, 2);
    step(1, 0, FILL_LVL);
    pat = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, FILL_LVL);
      pat |= int'(last_rd) << i;
    end
    chk("rd_pattern", pat, 8);
    step(1, 0, FILL_LVL);
    chk("valid_lag", int'(last_valid) * 2 + int'(last_rd), 2);

    // Steady flow against a FIFO model written at the IQ rate
    step(0, 0, 0);
    fcnt = 0; wph = 0; reads = 0; errs = 0; unlock = 0;
    for (int i = 0; i < 6000 && reads < 1000; i++) begin
      step(1, fcnt == 0, (fcnt > 15) ? 15 : fcnt);
      if (last_err) errs++;
      if (reads > 0 && !last_locked) unlock++;
      reads += int'(last_rd);
      if (last_aclr) fcnt = 0;
      else begin
        fcnt += int'(wph == 0) - int'(last_rd);
        wph = (wph + 1) % RD_DIV;
      end
    end
    chk("flow_reads", reads, 1000);
    chk("flow_errs", errs, 0);
    chk("flow_unlock", unlock, 0);

    // Underflow at a strobe slot
    goto_run();
    goto_slot();
    step(1, 1, FILL_LVL);
    chk("udf_err", last_err, 1);
    chk("udf_rd", last_rd, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
      if (last_state == 1 && last_aclr) n++;
    end
    chk("udf_reflush", n, 8);
`ifdef RX_FIFO_STATS_EN
    chk("udf_cnt_1", udf_cnt, 1);
`endif

    // Overflow on a non-strobe clock
    goto_run();
    step(1, 0, OVF_LVL);
    chk("ovf_err", last_err, 1);
    step(1, 0, 0);
    chk("ovf_flush", last_state, 1);
`ifdef RX_FIFO_STATS_EN
    chk("ovf_cnt_1", ovf_cnt, 1);
`endif

    // Underflow and overflow in one clock
    goto_run();
    goto_slot();
    step(1, 1, OVF_LVL);
    chk("both_err", last_err, 1);
`ifdef RX_FIFO_STATS_EN
    chk("both_udf", udf_cnt, 1);
    chk("both_ovf", ovf_cnt, 0);
`endif

    // No write clock: FILL times out twice
    goto_fill();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      step(1, 0, 0);
      n++;
      if (last_err) break;
    end
    chk("noclk_to1", n, FILL_TO);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      step(1, 0, 0);
      n++;
      if (last_err) break;
    end
    chk("noclk_to2", n, CLR_CYC + FILL_TO);
`ifdef RX_FIFO_STATS_EN
    chk("noclk_cnt_2", noclk_cnt, 2);
`endif

    // Disable at a strobe slot
    goto_run();
    goto_slot();
    step(0, 0, FILL_LVL);
    chk("dis_rd", last_rd, 0);
    step(0, 0, FILL_LVL);
    chk("dis_state", last_state, 0);
    chk("dis_aclr", last_aclr, 1);

    // Asynchronous reset mid-FILL
    goto_fill();
    step(1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_aclr", fifo_aclr, 1);
    chk("arst_state", state, 0);
    chk("arst_rd", rd_req, 0);
    chk("arst_locked", locked, 0);
    chk("arst_err", err_pulse, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r, uw;
      r = int'($urandom_range(0, 9));
      if (r < 6) uw = int'($urandom_range(6, 10));
      else if (r < 8) uw = int'($urandom_range(0, 15));
      else uw = int'($urandom_range(13, 15));
      stats_clr = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0, uw);
    end
    stats_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
